// File: rtl/histogram_sram_arbiter_pkg.sv
// Shared constants and helpers for the histogram SRAM arbiter: pixel/bin widths,
// enable levels, requester indices and the modulo-3 round-robin step.
package histogram_sram_arbiter_pkg;

    localparam int   PIXEL_BIT   = 8;
    localparam int   SRAM_DATA_W = 17;
    localparam int   NUM_REQ     = 3;
    localparam logic HIGH        = 1'b1;
    localparam logic LOW         = 1'b0;

    typedef enum logic [1:0] {
        REQ_HB  = 2'd0,
        REQ_HE  = 2'd1,
        REQ_OUT = 2'd2
    } req_idx_e;

    // (base + k) mod 3 for base, k in 0..2
    function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/histogram_sram_arbiter_rr.sv
// Three-way round-robin arbiter with per-requester lock; grants and pointer
// freeze while stalled or in reset.
module rr_arbiter_3
    import histogram_sram_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       stal_i,
    input  logic [2:0] req_i,
    input  logic [2:0] lock_i,
    output logic [2:0] gnt_o,
    output logic [1:0] gidx_o
);

    logic [1:0] r_ptr;
    logic       w_found;
    logic [1:0] w_idx;
    logic [1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = rr_step(r_ptr, 2'(k));
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (!rstn_i || stal_i) w_found = 1'b0;
    end

    assign gnt_o  = w_found ? (3'b001 << w_idx) : 3'b000;
    assign gidx_o = w_idx;

    // A locked winner keeps the head of the search for the next cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_ptr <= 2'd0;
        else if (w_found)
            r_ptr <= lock_i[w_idx] ? w_idx : rr_step(w_idx, 2'd1);
    end

endmodule

// File: rtl/histogram_sram_arbiter.sv
// Shares the 256x17 histogram SRAM between builder, equalizer and readout with
// independent read/write round-robin, same-cycle forwarding and a global stall.
module histogram_sram_arbiter
    import histogram_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = PIXEL_BIT,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      stal_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        wr_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      sram_wr_n_o,
    output logic [ADDR_W-1:0]         sram_addr_w_o,
    output logic [DATA_W-1:0]         sram_data_w_o,
    output logic                      sram_rd_n_o,
    output logic [ADDR_W-1:0]         sram_addr_r_o,
    input  logic [DATA_W-1:0]         sram_data_r_i
);

    logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] w_rgnt, w_wgnt;
    logic [1:0]         w_ridx, w_widx;
    logic               w_rd_go, w_wr_go, w_fwd;
    logic               w_cmd_rd_n, w_cmd_wr_n;
    logic [ADDR_W-1:0]  w_cmd_addr_r, w_cmd_addr_w;
    logic [DATA_W-1:0]  w_cmd_data_w;

    logic               r_last_rd_n, r_last_wr_n;
    logic [ADDR_W-1:0]  r_last_addr_r, r_last_addr_w;
    logic [DATA_W-1:0]  r_last_data_w;
    logic [NUM_REQ-1:0] r_s1_vld;
    logic               r_s1_fwd;
    logic [DATA_W-1:0]  r_s1_fdata;

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign w_addr[n]  = addr_i[n*ADDR_W +: ADDR_W];
        assign w_wdata[n] = wdata_i[n*DATA_W +: DATA_W];
    end

    rr_arbiter_3 u_rd_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .stal_i (stal_i),
        .req_i  (req_i & ~wr_i),
        .lock_i (lock_i),
        .gnt_o  (w_rgnt),
        .gidx_o (w_ridx)
    );

    rr_arbiter_3 u_wr_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .stal_i (stal_i),
        .req_i  (req_i & wr_i),
        .lock_i (lock_i),
        .gnt_o  (w_wgnt),
        .gidx_o (w_widx)
    );

    assign gnt_o   = w_rgnt | w_wgnt;
    assign w_rd_go = |w_rgnt;
    assign w_wr_go = |w_wgnt;

    assign w_cmd_rd_n   = w_rd_go ? LOW : HIGH;
    assign w_cmd_addr_r = w_rd_go ? w_addr[w_ridx]  : '0;
    assign w_cmd_wr_n   = w_wr_go ? LOW : HIGH;
    assign w_cmd_addr_w = w_wr_go ? w_addr[w_widx]  : '0;
    assign w_cmd_data_w = w_wr_go ? w_wdata[w_widx] : '0;

    // The SRAM returns pre-write data on a same-address collision.
    assign w_fwd = w_rd_go && w_wr_go && (w_cmd_addr_r == w_cmd_addr_w);

    assign sram_rd_n_o   = stal_i ? r_last_rd_n   : w_cmd_rd_n;
    assign sram_addr_r_o = stal_i ? r_last_addr_r : w_cmd_addr_r;
    assign sram_wr_n_o   = stal_i ? r_last_wr_n   : w_cmd_wr_n;
    assign sram_addr_w_o = stal_i ? r_last_addr_w : w_cmd_addr_w;
    assign sram_data_w_o = stal_i ? r_last_data_w : w_cmd_data_w;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_rd_n   <= HIGH;
            r_last_addr_r <= '0;
            r_last_wr_n   <= HIGH;
            r_last_addr_w <= '0;
            r_last_data_w <= '0;
        end else if (!stal_i) begin
            r_last_rd_n   <= w_cmd_rd_n;
            r_last_addr_r <= w_cmd_addr_r;
            r_last_wr_n   <= w_cmd_wr_n;
            r_last_addr_w <= w_cmd_addr_w;
            r_last_data_w <= w_cmd_data_w;
        end
    end

    // While stalled the read port re-issues the same address, so the SRAM
    // output in the first cycle after the stall still belongs to stage 1.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_vld   <= '0;
            r_s1_fwd   <= 1'b0;
            r_s1_fdata <= '0;
            rvalid_o   <= '0;
            rdata_o    <= '0;
        end else if (!stal_i) begin
            r_s1_vld   <= w_rgnt;
            r_s1_fwd   <= w_fwd;
            r_s1_fdata <= w_fwd ? w_cmd_data_w : '0;
            rvalid_o   <= r_s1_vld;
            if (|r_s1_vld)
                rdata_o <= r_s1_fwd ? r_s1_fdata : sram_data_r_i;
        end
    end

    assign busy_o = w_rd_go | (|r_s1_vld) | (|rvalid_o);

endmodule

// File: tb/tb_histogram_sram_arbiter.sv
// Directed bench for histogram_sram_arbiter with a behavioural read-before-write
// SRAM; expected values are hand-derived constants.
module tb_histogram_sram_arbiter;

    localparam int AW = 8;
    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rstn;
    logic          stal;
    logic [2:0]    req, wr, lock;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] wd   [3];
    logic [3*AW-1:0] addr_p;
    logic [3*DW-1:0] wd_p;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          sram_wr_n, sram_rd_n;
    logic [AW-1:0] sram_addr_w, sram_addr_r;
    logic [DW-1:0] sram_data_w;
    logic [DW-1:0] sram_data_r;
    logic [DW-1:0] mem [256];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    assign addr_p = {addr[2], addr[1], addr[0]};
    assign wd_p   = {wd[2], wd[1], wd[0]};

    always @(posedge clk) begin
        if (!sram_wr_n) mem[sram_addr_w] <= sram_data_w;
        if (!sram_rd_n) sram_data_r <= mem[sram_addr_r];
    end

    histogram_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .stal_i        (stal),
        .req_i         (req),
        .wr_i          (wr),
        .lock_i        (lock),
        .addr_i        (addr_p),
        .wdata_i       (wd_p),
        .gnt_o         (gnt),
        .rvalid_o      (rvalid),
        .rdata_o       (rdata),
        .busy_o        (busy),
        .sram_wr_n_o   (sram_wr_n),
        .sram_addr_w_o (sram_addr_w),
        .sram_data_w_o (sram_data_w),
        .sram_rd_n_o   (sram_rd_n),
        .sram_addr_r_o (sram_addr_r),
        .sram_data_r_i (sram_data_r)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 517 + 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},    32'(gnt), 0);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_rdata"},  32'(rdata), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_wr_n"},   32'(sram_wr_n), 1);
        chk({tag, "_rd_n"},   32'(sram_rd_n), 1);
        chk({tag, "_addr_w"}, 32'(sram_addr_w), 0);
        chk({tag, "_data_w"}, 32'(sram_data_w), 0);
        chk({tag, "_addr_r"}, 32'(sram_addr_r), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req = '0; wr = '0; lock = '0;
    endtask

    initial begin
        rstn = 1'b0; stal = 1'b0;
        idle_in();
        for (int n = 0; n < 3; n++) begin addr[n] = '0; wd[n] = '0; end
        step();

        // Reset holds every port idle even with requests pending.
        req = 3'b111; wr = 3'b001; addr[0] = 8'h12; wd[0] = 17'h1; addr[1] = 8'h34;
        #1; chk_idle("reset");
        step();

        // Read granted, then reset hits while it is in flight.
        rstn = 1'b1; req = 3'b100; wr = '0; addr[2] = 8'h03;
        #1; chk("rst_rd_gnt", 32'(gnt), 32'b100);
        step();
        idle_in(); rstn = 1'b0;
        #1; chk_idle("rst_mid");
        step();
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; chk("rst_no_rvalid", 32'(rvalid), 0);
            step();
        end

        // Builder preloads addr 5 and 9.
        req = 3'b001; wr = 3'b001; addr[0] = 8'h05; wd[0] = 17'h00055;
        #1; chk("wr5_gnt", 32'(gnt), 32'b001);
        chk("wr5_wr_n", 32'(sram_wr_n), 0);
        chk("wr5_addr", 32'(sram_addr_w), 32'h05);
        step();
        addr[0] = 8'h09; wd[0] = 17'h00099;
        #1; chk("wr9_data", 32'(sram_data_w), 32'h00099);
        step();

        // Round-robin between builder (addr 5) and equalizer (addr 9) reads.
        addr[0] = 8'h05; addr[1] = 8'h09;
        for (int c = 0; c < 6; c++) begin
            req = (c < 4) ? 3'b011 : 3'b000; wr = '0;
            #1;
            if (c < 4) chk("rr_gnt", 32'(gnt), (c % 2) ? 32'b010 : 32'b001);
            if (c >= 2) begin
                chk("rr_rvalid", 32'(rvalid), (c % 2) ? 32'b010 : 32'b001);
                chk("rr_rdata",  32'(rdata),  (c % 2) ? 32'h00099 : 32'h00055);
            end
            step();
        end
        idle_in();
        #1; chk("rr_drained", 32'(rvalid), 0);
        step();

        // Same-cycle write/read collision on 0x10, then a plain re-read.
        req = 3'b101; wr = 3'b001; addr[0] = 8'h10; wd[0] = 17'h1ABCD; addr[2] = 8'h10;
        #1; chk("fwd_gnt", 32'(gnt), 32'b101);
        step();
        req = 3'b100; wr = '0;
        #1; step();
        idle_in();
        #1; chk("fwd_rvalid", 32'(rvalid), 32'b100);
        chk("fwd_rdata", 32'(rdata), 32'h1ABCD);
        step();
        #1; chk("fwd_next_rvalid", 32'(rvalid), 32'b100);
        chk("fwd_next_rdata", 32'(rdata), 32'h1ABCD);
        step();
        step();

        // Equalizer lock keeps the read port for four cycles against readout.
        addr[1] = 8'h05; addr[2] = 8'h09;
        for (int c = 0; c < 5; c++) begin
            req  = (c < 4) ? 3'b110 : 3'b100;
            lock = (c < 4) ? 3'b010 : 3'b000;
            wr   = '0;
            #1; chk("lock_gnt", 32'(gnt), (c < 4) ? 32'b010 : 32'b100);
            step();
        end
        idle_in();
        for (int c = 0; c < 3; c++) step();
        #1; chk("lock_drained", 32'(rvalid), 0);

        // Readout read + builder write, then a 3-cycle stall.
        req = 3'b101; wr = 3'b001; addr[0] = 8'h20; wd[0] = 17'h12345; addr[2] = 8'h09;
        #1; chk("stl_gnt", 32'(gnt), 32'b101);
        step();
        stal = 1'b1; req = 3'b100; wr = '0; addr[2] = 8'h33;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stl_gnt0",   32'(gnt), 0);
            chk("stl_rd_n",   32'(sram_rd_n), 0);
            chk("stl_addr_r", 32'(sram_addr_r), 32'h09);
            chk("stl_wr_n",   32'(sram_wr_n), 0);
            chk("stl_addr_w", 32'(sram_addr_w), 32'h20);
            chk("stl_data_w", 32'(sram_data_w), 32'h12345);
            chk("stl_rvalid", 32'(rvalid), 0);
            chk("stl_busy",   32'(busy), 1);
            step();
        end
        stal = 1'b0; idle_in();
        #1; chk("stl_early", 32'(rvalid), 0);
        step();
        #1; chk("stl_rvalid_t5", 32'(rvalid), 32'b100);
        chk("stl_rdata", 32'(rdata), 32'h00099);
        step();
        #1; chk("stl_one_shot", 32'(rvalid), 0);
        step();

        // Full sweep: builder writes all bins, readout reads them back.
        for (int i = 0; i < 256; i++) begin
            req = 3'b001; wr = 3'b001; addr[0] = AW'(i); wd[0] = pat(i);
            #1; if (i == 0 || i == 255) chk("sweep_wr_gnt", 32'(gnt), 32'b001);
            step();
        end
        for (int c = 0; c < 259; c++) begin
            req = (c < 256) ? 3'b100 : 3'b000; wr = '0;
            addr[2] = AW'(c);
            #1;
            if (c >= 2 && c < 258) begin
                chk("sweep_rvalid", 32'(rvalid), 32'b100);
                chk("sweep_rdata",  32'(rdata), 32'(pat(c - 2)));
            end
            if (c == 257) chk("sweep_busy_last", 32'(busy), 1);
            if (c == 258) chk("sweep_busy_drop", 32'(busy), 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
